// File: rtl/bus_pkg.sv
// Shared definitions for the 3-master / 2-slave bus: FSM states, select and grant encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  // Slave responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } bus_state_e;

  // Arbiter one-hot slave select
  localparam logic [1:0] SEL_S0 = 2'b01;
  localparam logic [1:0] SEL_S1 = 2'b10;

  // Arbiter one-hot master grant
  localparam logic [2:0] GNT_M0 = 3'b001;
  localparam logic [2:0] GNT_M1 = 3'b010;
  localparam logic [2:0] GNT_M2 = 3'b100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One shared down-counter covers the wait, ack and gap phases
  function automatic int cnt_width(input int w, input int a, input int g);
    return $clog2(max3(w, a, g) + 1);
  endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Synchronous single-port word memory behind the slave responder.
// Latency: write commits and read data registers on the edge where en=1 (1 cycle).
// Backpressure: none; one access per enabled cycle, read register holds between reads.
module bus_slave_ram
  import bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Single port: either write the word or register the read; read data holds through writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_slave_resp.sv
// Slave responder: accepts one bus command, accesses memory after WAIT_CYC, pulses ack, then enforces a quiet gap.
// Latency: ack rises WAIT_CYC+1 edges after the accept edge, stays high ACK_CYC cycles, GAP_CYC quiet cycles follow.
// Backpressure: commands are taken only in IDLE; cmd_valid held during WAIT/ACK/GAP is simply not accepted (no queue).
module bus_slave_resp #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1,
  parameter int ACK_CYC  = 1,
  parameter int GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              cmd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  import bus_pkg::*;

  localparam int CNT_W = cnt_width(WAIT_CYC, ACK_CYC, GAP_CYC);

  // WAIT is held for WAIT_CYC+1 cycles (count WAIT_CYC..0) so ack rises WAIT_CYC+1
  // edges after accept; with WAIT_CYC=0 this is just the single command-register cycle.
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] ACK_LD  = CNT_W'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  bus_state_e        state_q;
  bus_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  cmd_t              cmd_q;
  logic              cnt_zero;
  logic              cmd_accept;
  logic              mem_en;
  logic              rd_seen_q;
  logic [DATA_W-1:0] ram_rd_dat;

  assign cnt_zero   = (cnt_q == '0);
  assign cmd_accept = (state_q == ST_IDLE) && sel && cmd_valid;

  // State and phase counter; async reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Command is sampled only on the accept edge; later bus changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
    end else if (cmd_accept) begin
      cmd_q.we    <= we;
      cmd_q.addr  <= addr;
      cmd_q.wdata <= wdata;
    end
  end

  // Next state: IDLE -> WAIT -> ACK -> GAP -> IDLE, with sel loss in WAIT aborting
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WAIT_LD;
        end
      end
      ST_WAIT: begin
        if (!sel) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_zero) begin
          state_nxt = ST_ACK;
          cnt_nxt   = ACK_LD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      ST_ACK: begin
        if (cnt_zero) begin
          state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: memory access fires on the WAIT->ACK edge so read data lands with ack
  always_comb begin
    ack    = (state_q == ST_ACK);
    busy   = (state_q != ST_IDLE);
    mem_en = (state_q == ST_WAIT) && sel && cnt_zero;
  end

  // Memory read register is not reset, so rdata is forced to zero until a read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_seen_q <= 1'b0;
    end else if (mem_en && !cmd_q.we) begin
      rd_seen_q <= 1'b1;
    end
  end

  assign rdata = rd_seen_q ? ram_rd_dat : '0;

  bus_slave_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (cmd_q.we),
    .addr  (cmd_q.addr),
    .wdata (cmd_q.wdata),
    .rdata (ram_rd_dat)
  );

endmodule

// File: tb/tb_bus_slave_resp.sv
// Directed bench for bus_slave_resp: three instances (defaults, WAIT_CYC=3, WAIT_CYC=0/ACK_CYC=3).
// Inputs are driven and outputs sampled on the falling clock edge.
// Instances share the command bus; only the instance whose sel bit is high responds.
module tb_bus_slave_resp;

  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  sel_v;
  wire  [2:0]  ack_v;
  wire  [2:0]  busy_v;
  wire  [31:0] rd0;
  wire  [31:0] rd1;
  wire  [31:0] rd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_slave_resp #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(1), .ACK_CYC(1), .GAP_CYC(2)) u_def (
    .clk(clk), .rst(rst), .sel(sel_v[0]), .cmd_valid(cmd_valid), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[0]), .rdata(rd0), .busy(busy_v[0]));

  bus_slave_resp #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(3), .ACK_CYC(1), .GAP_CYC(2)) u_w3 (
    .clk(clk), .rst(rst), .sel(sel_v[1]), .cmd_valid(cmd_valid), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[1]), .rdata(rd1), .busy(busy_v[1]));

  bus_slave_resp #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(0), .ACK_CYC(3), .GAP_CYC(2)) u_a3 (
    .clk(clk), .rst(rst), .sel(sel_v[2]), .cmd_valid(cmd_valid), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack_v[2]), .rdata(rd2), .busy(busy_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int idx);
    case (idx)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  // Wait (bounded) for the instance to return to IDLE, then release sel
  task automatic wait_idle(input int idx);
    for (int k = 0; k < 40 && busy_v[idx]; k++) @(negedge clk);
    chk("idle_timeout", {31'd0, busy_v[idx]}, 32'd0);
    sel_v = 3'b000;
  endtask

  // One complete transaction with a single-cycle cmd_valid pulse; returns rdata seen with ack
  task automatic xact(input int idx, input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    bit got;
    sel_v     = 3'b001 << idx;
    cmd_valid = 1'b1;
    we        = w;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (ack_v[idx]) begin
        got = 1'b1;
        rd  = rd_of(idx);
      end else begin
        @(negedge clk);
      end
    end
    chk("xact_ack_seen", {31'd0, got}, 32'd1);
    wait_idle(idx);
  endtask

  task automatic apply_gnt(input logic [2:0] g);
    cmd_valid = 1'b1;
    we        = 1'b1;
    if (g == GNT_M0) begin
      addr  = 8'h50;
      wdata = 32'h0000_00A0;
    end else begin
      addr  = 8'h51;
      wdata = 32'h0000_00B1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  gnt;
    int pulses, low_run, min_low, high_run, max_high, k;
    int acks0, acks1, fall_at, idle_k, rise1_k;
    bit prev, done, saw;

    rst = 1'b1; cmd_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel_v = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ack", {29'd0, ack_v}, 32'd0);
    chk("rst_busy", {29'd0, busy_v}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known memory contents
    xact(1, 1'b1, 8'h20, 32'h0000_0000, rd);
    xact(1, 1'b1, 8'h21, 32'h5A5A_5A5A, rd);
    xact(1, 1'b0, 8'h21, 32'h0, rd);
    chk("setup_rd21", rd, 32'h5A5A_5A5A);
    xact(0, 1'b1, 8'h30, 32'h0000_0000, rd);
    xact(2, 1'b1, 8'hFF, 32'hA5A5_0FF0, rd);

    // 1: write then read, defaults; bus changes after accept are ignored
    sel_v = 3'b001; cmd_valid = 1'b1; we = 1'b1; addr = 8'h10; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b0; addr = 8'h11; wdata = 32'h0;
    chk("t1_busy_after_accept", {31'd0, busy_v[0]}, 32'd1);
    chk("t1_ack_n1", {31'd0, ack_v[0]}, 32'd0);
    @(negedge clk);
    chk("t1_ack_n2", {31'd0, ack_v[0]}, 32'd0);
    @(negedge clk);
    chk("t1_ack_rise", {31'd0, ack_v[0]}, 32'd1);
    @(negedge clk);
    chk("t1_ack_width", {31'd0, ack_v[0]}, 32'd0);
    chk("t1_gap_busy", {31'd0, busy_v[0]}, 32'd1);
    cmd_valid = 1'b1; we = 1'b0; addr = 8'h10;
    @(negedge clk);
    @(negedge clk);
    chk("t1_gap_ignore", {31'd0, busy_v[0]}, 32'd0);
    @(negedge clk);
    chk("t1_rd_accept", {31'd0, busy_v[0]}, 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd_ack_n2", {31'd0, ack_v[0]}, 32'd0);
    @(negedge clk);
    chk("t1_rd_ack", {31'd0, ack_v[0]}, 32'd1);
    chk("t1_rd_data", rd0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_rd_hold", rd0, 32'hDEAD_BEEF);
    wait_idle(0);

    // 2: sel dropped during WAIT (WAIT_CYC=3) aborts with no write and no ack
    sel_v = 3'b010; cmd_valid = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'h0000_1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t2_busy", {31'd0, busy_v[1]}, 32'd1);
    sel_v = 3'b000;
    @(negedge clk);
    chk("t2_abort_busy", {31'd0, busy_v[1]}, 32'd0);
    chk("t2_rdata_keep", rd1, 32'h5A5A_5A5A);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | ack_v[1];
    end
    chk("t2_no_ack", {31'd0, saw}, 32'd0);
    xact(1, 1'b0, 8'h20, 32'h0, rd);
    chk("t2_no_commit", rd, 32'h0);

    // 3: cmd_valid/sel held for three writes; pulses 1 wide, 5 low cycles apart
    sel_v = 3'b001; cmd_valid = 1'b1; we = 1'b1; addr = 8'h40; wdata = 32'h1111_0040;
    pulses = 0; low_run = 0; min_low = 999; high_run = 0; max_high = 0; prev = 1'b0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (ack_v[0]) begin
        high_run++;
        if (!prev) begin
          pulses++;
          if (pulses > 1 && low_run < min_low) min_low = low_run;
          addr  = 8'h40 + 8'(pulses);
          wdata = 32'h1111_0040 + 32'(pulses);
          if (pulses == 3) cmd_valid = 1'b0;
        end
        low_run = 0;
      end else begin
        if (prev && high_run > max_high) max_high = high_run;
        high_run = 0;
        low_run++;
      end
      prev = ack_v[0];
    end while (k < 80 && !(pulses == 3 && !ack_v[0]));
    chk("t3_pulses", 32'(pulses), 32'd3);
    chk("t3_width", 32'(max_high), 32'd1);
    chk("t3_min_low", 32'(min_low), 32'd5);
    cmd_valid = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      xact(0, 1'b0, 8'h40 + 8'(i), 32'h0, rd);
      chk("t3_readback", rd, 32'h1111_0040 + 32'(i));
    end

    // 4: WAIT_CYC=0, ACK_CYC=3 read of 0xFF
    sel_v = 3'b100; cmd_valid = 1'b1; we = 1'b0; addr = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0; addr = 8'h00;
    chk("t4_ack_n1", {31'd0, ack_v[2]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ack_high", {31'd0, ack_v[2]}, 32'd1);
      chk("t4_rdata", rd2, 32'hA5A5_0FF0);
    end
    @(negedge clk);
    chk("t4_ack_fall", {31'd0, ack_v[2]}, 32'd0);
    chk("t4_rdata_hold", rd2, 32'hA5A5_0FF0);
    wait_idle(2);

    // 5a: reset during WAIT: write to 0x30 never commits, rdata cleared
    sel_v = 3'b001; cmd_valid = 1'b1; we = 1'b1; addr = 8'h30; wdata = 32'hCAFE_0030;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_wait_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t5_rdata_rst", rd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sel_v = 3'b000;
    xact(0, 1'b0, 8'h30, 32'h0, rd);
    chk("t5_no_commit", rd, 32'h0);

    // 5b: reset during ACK drops ack and busy immediately; write already committed
    sel_v = 3'b001; cmd_valid = 1'b1; we = 1'b1; addr = 8'h31; wdata = 32'hBEEF_0031;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_ack", {31'd0, ack_v[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_ack_async", {31'd0, ack_v[0]}, 32'd0);
    chk("t5_busy_async", {31'd0, busy_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sel_v = 3'b000;
    xact(0, 1'b0, 8'h31, 32'h0, rd);
    chk("t5_ack_committed", rd, 32'hBEEF_0031);

    // 6: arbiter model, M0 then M1 on slave 0; grant switches when M0's ack falls
    gnt = GNT_M0;
    sel_v = {1'b0, SEL_S0};
    apply_gnt(gnt);
    acks0 = 0; acks1 = 0; fall_at = -1; idle_k = -1; rise1_k = -1; prev = 1'b0; done = 1'b0; k = 0;
    while (k < 80 && !done) begin
      @(negedge clk);
      k++;
      if (ack_v[0] && !prev) begin
        if (gnt == GNT_M0) acks0++;
        else begin
          acks1++;
          rise1_k = k;
        end
      end
      if (!ack_v[0] && prev) begin
        if (gnt == GNT_M0) begin
          gnt = GNT_M1;
          apply_gnt(gnt);
          fall_at = k;
        end else begin
          cmd_valid = 1'b0;
          done = 1'b1;
        end
      end
      if (fall_at >= 0 && idle_k < 0 && k > fall_at && !busy_v[0]) idle_k = k;
      prev = ack_v[0];
    end
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_acks_m0", 32'(acks0), 32'd1);
    chk("t6_acks_m1", 32'(acks1), 32'd1);
    chk("t6_gap_len", 32'(idle_k - fall_at), 32'd2);
    chk("t6_m1_ack_offset", 32'(rise1_k - fall_at), 32'd5);
    cmd_valid = 1'b0;
    wait_idle(0);
    xact(0, 1'b0, 8'h50, 32'h0, rd);
    chk("t6_m0_word", rd, 32'h0000_00A0);
    xact(0, 1'b0, 8'h51, 32'h0, rd);
    chk("t6_m1_word", rd, 32'h0000_00B1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_slave_resp.md
Name: bus_slave_resp

Overview:
- Slave-side responder for the 3-master shared bus; sits behind one bit of the arbiter's 2-bit one-hot slave select.
- Accepts the granted master's command (addr/we/wdata) and performs a single-port memory access after a programmable wait.
- Signals completion with an ack pulse whose falling edge the arbiter uses as command-done.
- Enforces a post-ack quiet gap so the arbiter can re-arbitrate before another command is accepted.

Parameters:
ADDR_W, 8, address width; memory depth = 2**ADDR_W words
DATA_W, 32, data width
WAIT_CYC, 1, cycles from accept to ack rise (0 allowed)
ACK_CYC, 1, cycles ack stays high (>=1)
GAP_CYC, 2, cycles after ack falls during which commands are ignored (>=0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
sel  in  1  this slave's select bit from arbiter sel
cmd_valid  in  1  granted master presents a command
we  in  1  1=write, 0=read
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
ack  out  1  transaction complete strobe to master and arbiter
rdata  out  DATA_W  read data, valid while ack=1, held afterwards
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst=1 sets state IDLE, ack=0, rdata=0, busy=0, and clears all counters. Memory contents are not reset.
- Reset mid-transaction aborts immediately: no write commits and ack drops asynchronously.
- States: IDLE, WAIT, ACK, GAP.
- IDLE: on sel=1 and cmd_valid=1 at a clock edge, latch we/addr/wdata and load the wait counter.
  - If WAIT_CYC=0, go directly to ACK (ack rises on the next edge; 1-cycle latency).
  - Otherwise go to WAIT.
- WAIT: count WAIT_CYC cycles. Ack rises WAIT_CYC+1 edges after the accept edge.
  - If sel drops while in WAIT: abort to IDLE, no write, no ack, rdata unchanged.
- WAIT->ACK transition edge: the access executes.
  - Write: mem[addr_l] <= wdata_l.
  - Read: rdata <= mem[addr_l].
- ACK: ack=1 for exactly ACK_CYC cycles. Completes regardless of sel or cmd_valid changes.
- ACK->GAP: ack falls (the arbiter detects the fall).
  - If GAP_CYC=0, go to IDLE directly.
- GAP: ignore sel and cmd_valid for GAP_CYC cycles, then IDLE.
  - The default GAP_CYC=2 covers the arbiter's registered ack-falling detection plus its state update, so the next master's select is stable before the next accept.
- Commands are accepted only in IDLE. A cmd_valid held high across transactions is accepted again only after GAP; there is no queueing.
- Inputs are sampled only on the accept edge. Changes to addr/wdata/we after accept are ignored.
- rdata is updated only by reads and holds its value through subsequent writes.
- Counters are sized $clog2(max(WAIT_CYC,ACK_CYC,GAP_CYC)+1). Counting down to zero; no wrap-around is possible.
- busy=1 in WAIT/ACK/GAP.
- Address is full-range; there are no out-of-range accesses.

Decomposition:
- Shared package bus_pkg:
  - state enum for IDLE/WAIT/ACK/GAP;
  - slave select encodings SEL_S0=2'b01, SEL_S1=2'b10;
  - master grant encodings GNT_M0=3'b001, GNT_M1=3'b010, GNT_M2=3'b100.
- One sub-module, bus_slave_ram: synchronous single-port memory.
  - Ports: clk, en, we, addr, wdata, rdata.
  - Registered read, 1-cycle latency. The FSM issues en on the WAIT->ACK edge and aligns rdata with ack.

Test Plan:
1. Write then read, defaults: accept write addr=0x10 wdata=0xDEADBEEF -> ack high exactly 1 cycle, 2 edges after accept. GAP 2 cycles, then accept read addr=0x10 -> rdata=0xDEADBEEF while ack=1.
2. Sel dropped during WAIT with WAIT_CYC=3: write addr=0x20 data=0x1234, sel=0 after 1 cycle -> no ack, busy falls next edge. Later read of 0x20 returns its prior value (0 after fresh init by the bench).
3. cmd_valid and sel held high continuously for 3 writes -> exactly 3 ack pulses. Each pulse separated by >=GAP_CYC+1 low cycles; all 3 words written.
4. WAIT_CYC=0, ACK_CYC=3: read addr=0xFF -> ack rises on the edge after accept, stays high 3 cycles, rdata stable throughout.
5. rst asserted during ACK -> ack=0 and busy=0 immediately. Pending write to 0x30 does not commit if rst precedes the WAIT->ACK edge; rdata=0 after reset.
6. Arbiter integration, M0 and M1 both targeting this slave: exactly one ack per grant. Arbiter gnt switches 001->010 after M0's ack falls; M1's command is accepted only after GAP.
